// File: rtl/rggen_bit_field_rc_counter_if.sv
// Register-block bit field bus: valid/masks/write data in, read data and raw value out.
// Ports: valid, read_mask, write_mask, write_data (to field); read_data, value (from field).
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid,
    output read_mask,
    output write_mask,
    output write_data,
    input  read_data,
    input  value
  );

  modport bit_field (
    input  valid,
    input  read_mask,
    input  write_mask,
    input  write_data,
    output read_data,
    output value
  );
endinterface

// File: rtl/rggen_bit_field_rc_counter.sv
// Read-to-clear event counter field: {overflow, count}, optional saturation, threshold flag.
// Ports: i_clk, i_rst_n, bit_field_if, i_enable, i_inc, i_clear, i_threshold, o_value, o_overflow, o_threshold_hit.
module rggen_bit_field_rc_counter #(
  parameter int               WIDTH         = 16,
  parameter int               INC_WIDTH     = 1,
  parameter bit               SATURATE      = 1'b1,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic                 i_enable,
  input  logic [INC_WIDTH-1:0] i_inc,
  input  logic                 i_clear,
  input  logic [WIDTH-1:0]     i_threshold,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_overflow,
  output logic                 o_threshold_hit
);

  logic             read;
  logic             clear_req;
  logic             update;
  logic [WIDTH:0]   base;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             hit_q;
  logic             hit_d;
  logic             write_unused;

  // Field is read-only; write side of the bus is intentionally ignored.
  assign write_unused = ^{bit_field_if.write_mask, bit_field_if.write_data};

  assign read      = bit_field_if.valid && (bit_field_if.read_mask != '0);
  assign clear_req = read || i_clear;

  assign base = clear_req ? '0 : {1'b0, count_q};
  assign add  = i_enable
              ? {{(WIDTH+1-INC_WIDTH){1'b0}}, i_inc}
              : '0;
  assign sum   = base + add;
  assign carry = sum[WIDTH];

  // Increments landing in a clear cycle count after the clear.
  assign update = clear_req || (add != '0);

  always_comb begin
    count_d = sum[WIDTH-1:0];
    if (carry && SATURATE) begin
      count_d = '1;
    end
    ovf_d = (clear_req ? 1'b0 : ovf_q) | carry;
    hit_d = (i_threshold != '0) && (count_d >= i_threshold);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= INITIAL_VALUE;
      ovf_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else if (update) begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
    end
  end

  assign bit_field_if.value     = {ovf_q, count_q};
  assign bit_field_if.read_data = {ovf_q, count_q}
                                & bit_field_if.read_mask;

  assign o_value         = count_q;
  assign o_overflow      = ovf_q;
  assign o_threshold_hit = hit_q;

endmodule

// File: tb/tb_rggen_bit_field_rc_counter.sv
// Bench for rggen_bit_field_rc_counter: 16-bit saturating instance plus 4-bit saturating/wrapping pair.
// Ports: none (top level); drives DUT inputs, checks against an arithmetic model every cycle.
module tb_rggen_bit_field_rc_counter;

  typedef struct packed {
    int c;
    bit o;
    bit h;
  } mst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_on = 1'b0;
  int   tests = 0;
  int   fails = 0;

  rggen_bit_field_if #(17) bf16 ();
  rggen_bit_field_if #(5)  bf4s ();
  rggen_bit_field_if #(5)  bf4w ();

  logic        en16, clr16;
  logic [3:0]  inc16;
  logic [15:0] thr16;
  logic [15:0] val16;
  logic        ov16, hit16;

  logic        en4, clr4, v4;
  logic [3:0]  inc4, thr4;
  logic [4:0]  rm4;
  logic [3:0]  val4s, val4w;
  logic        ov4s, ov4w, hit4s, hit4w;

  assign bf4s.valid      = v4;
  assign bf4s.read_mask  = rm4;
  assign bf4s.write_mask = 5'h00;
  assign bf4s.write_data = 5'h00;
  assign bf4w.valid      = v4;
  assign bf4w.read_mask  = rm4;
  assign bf4w.write_mask = 5'h00;
  assign bf4w.write_data = 5'h00;

  always #5 clk = ~clk;

  rggen_bit_field_rc_counter #(
    .WIDTH(16), .INC_WIDTH(4), .SATURATE(1'b1), .INITIAL_VALUE(16'd5)
  ) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(bf16),
    .i_enable(en16), .i_inc(inc16), .i_clear(clr16), .i_threshold(thr16),
    .o_value(val16), .o_overflow(ov16), .o_threshold_hit(hit16)
  );

  rggen_bit_field_rc_counter #(
    .WIDTH(4), .INC_WIDTH(4), .SATURATE(1'b1), .INITIAL_VALUE(4'd0)
  ) dut4s (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(bf4s),
    .i_enable(en4), .i_inc(inc4), .i_clear(clr4), .i_threshold(thr4),
    .o_value(val4s), .o_overflow(ov4s), .o_threshold_hit(hit4s)
  );

  rggen_bit_field_rc_counter #(
    .WIDTH(4), .INC_WIDTH(4), .SATURATE(1'b0), .INITIAL_VALUE(4'd0)
  ) dut4w (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(bf4w),
    .i_enable(en4), .i_inc(inc4), .i_clear(clr4), .i_threshold(thr4),
    .o_value(val4w), .o_overflow(ov4w), .o_threshold_hit(hit4w)
  );

  // Arithmetic model: events accumulate as plain integers, limited at 2**w.
  function automatic mst_t mstep(input int w, input bit sat, input bit rd,
                                 input int add, input int thr, input mst_t s);
    mst_t r;
    int   full;
    int   t;
    r = s;
    full = 1 << w;
    if (!rd && add == 0) return r;
    t = (rd ? 0 : s.c) + add;
    r.o = rd ? 1'b0 : s.o;
    if (t >= full) begin
      r.o = 1'b1;
      t = sat ? full - 1 : t - full;
    end
    r.c = t;
    r.h = (thr != 0) && (t >= thr);
    return r;
  endfunction

  mst_t m16, m4s, m4w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 <= '{c: 5, o: 1'b0, h: 1'b0};
      m4s <= '{c: 0, o: 1'b0, h: 1'b0};
      m4w <= '{c: 0, o: 1'b0, h: 1'b0};
    end else begin
      m16 <= mstep(16, 1'b1,
                   (bf16.valid && bf16.read_mask != 0) || clr16,
                   en16 ? int'(inc16) : 0, int'(thr16), m16);
      m4s <= mstep(4, 1'b1, (v4 && rm4 != 0) || clr4,
                   en4 ? int'(inc4) : 0, int'(thr4), m4s);
      m4w <= mstep(4, 1'b0, (v4 && rm4 != 0) || clr4,
                   en4 ? int'(inc4) : 0, int'(thr4), m4w);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint fld(input int w, input mst_t s);
    return (longint'(s.o) << w) | longint'(s.c);
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m16_value", longint'(val16), longint'(m16.c));
      chk("m16_ovf",   longint'(ov16),  longint'(m16.o));
      chk("m16_hit",   longint'(hit16), longint'(m16.h));
      chk("m16_field", longint'(bf16.value), fld(16, m16));
      chk("m16_rdata", longint'(bf16.read_data),
          fld(16, m16) & longint'(bf16.read_mask));
      chk("m4s_value", longint'(val4s), longint'(m4s.c));
      chk("m4s_ovf",   longint'(ov4s),  longint'(m4s.o));
      chk("m4s_rdata", longint'(bf4s.read_data), fld(4, m4s) & longint'(rm4));
      chk("m4w_value", longint'(val4w), longint'(m4w.c));
      chk("m4w_ovf",   longint'(ov4w),  longint'(m4w.o));
      chk("m4w_rdata", longint'(bf4w.read_data), fld(4, m4w) & longint'(rm4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bf16.valid = 1'b0; bf16.read_mask = '0;
    bf16.write_mask = '0; bf16.write_data = '0;
    en16 = 1'b0; clr16 = 1'b0; inc16 = '0; thr16 = '0;
    en4 = 1'b0; clr4 = 1'b0; inc4 = '0; thr4 = '0;
    v4 = 1'b0; rm4 = '0;

    repeat (2) tick();
    chk("rst_value", longint'(val16), 5);
    chk("rst_ovf",   longint'(ov16), 0);
    chk("rst_hit",   longint'(hit16), 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Write attempt must not disturb the field.
    bf16.valid = 1'b1; bf16.write_mask = '1; bf16.write_data = 17'h01234;
    tick();
    bf16.valid = 1'b0; bf16.write_mask = '0; bf16.write_data = '0;
    chk("write_ignored", longint'(val16), 5);

    // Ten events then a read.
    clr16 = 1'b1; tick(); clr16 = 1'b0;
    chk("hw_clear", longint'(val16), 0);
    en16 = 1'b1; inc16 = 4'd1;
    repeat (10) tick();
    inc16 = 4'd0;
    bf16.valid = 1'b1; bf16.read_mask = '1;
    #1 chk("read_10", longint'(bf16.read_data), 17'h0000A);
    tick();
    bf16.valid = 1'b0; bf16.read_mask = '0;
    chk("after_read", longint'(val16), 0);

    // Read coinciding with an increment.
    inc16 = 4'd7; tick();
    inc16 = 4'd3; bf16.valid = 1'b1; bf16.read_mask = '1;
    #1 chk("read_7", longint'(bf16.read_data), 7);
    tick();
    inc16 = 4'd0; bf16.valid = 1'b0; bf16.read_mask = '0;
    chk("kept_inc", longint'(val16), 3);
    chk("kept_ovf", longint'(ov16), 0);

    // Threshold flag.
    clr16 = 1'b1; tick(); clr16 = 1'b0;
    thr16 = 16'd8; inc16 = 4'd1;
    repeat (7) tick();
    chk("thr_below_val", longint'(val16), 7);
    chk("thr_below_hit", longint'(hit16), 0);
    tick();
    chk("thr_at_val", longint'(val16), 8);
    chk("thr_at_hit", longint'(hit16), 1);
    inc16 = 4'd0; clr16 = 1'b1; tick(); clr16 = 1'b0;
    chk("thr_clr_hit", longint'(hit16), 0);
    thr16 = 16'd0; inc16 = 4'd1;
    repeat (20) tick();
    chk("thr_off_val", longint'(val16), 20);
    chk("thr_off_hit", longint'(hit16), 0);

    // Disabled increments hold the count.
    en16 = 1'b0;
    repeat (3) tick();
    chk("disabled_hold", longint'(val16), 20);
    en16 = 1'b1;
    repeat (3) tick();
    chk("reenabled", longint'(val16), 23);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 chk("async_rst_val", longint'(val16), 5);
    chk("async_rst_ovf", longint'(ov16), 0);
    tick();
    chk("rst_hold", longint'(val16), 5);
    rst_n = 1'b1;
    tick();
    chk("resume", longint'(val16), 6);
    inc16 = 4'd0; en16 = 1'b0;

    // 4-bit saturate vs wrap.
    en4 = 1'b1; inc4 = 4'd14; tick();
    chk("w4_start_s", longint'(val4s), 14);
    chk("w4_start_w", longint'(val4w), 14);
    inc4 = 4'd3; tick(); inc4 = 4'd0;
    chk("sat_val", longint'(val4s), 15);
    chk("sat_ovf", longint'(ov4s), 1);
    chk("wrap_val", longint'(val4w), 1);
    chk("wrap_ovf", longint'(ov4w), 1);
    v4 = 1'b1; rm4 = 5'h1F;
    #1 chk("sat_rdata", longint'(bf4s.read_data), 5'h1F);
    chk("wrap_rdata", longint'(bf4w.read_data), 5'h11);
    tick();
    v4 = 1'b0; rm4 = 5'h00;
    chk("sat_clr", longint'({ov4s, val4s}), 0);
    chk("wrap_clr", longint'({ov4w, val4w}), 0);
    inc4 = 4'd15; tick();
    inc4 = 4'd1; tick(); inc4 = 4'd0;
    chk("sat_pin_val", longint'(val4s), 15);
    chk("sat_pin_ovf", longint'(ov4s), 1);
    chk("wrap_edge_val", longint'(val4w), 0);
    chk("wrap_edge_ovf", longint'(ov4w), 1);

    repeat (2) tick();
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
